mem_io_responder: RTL and testbench

- Memory/IO responder on the CPU's byte-wide memory bus: services the bus address, write strobe and byte-data outputs, and returns read data on the CPU's byte-data input.
- Contains the byte RAM, UART TX FIFO, optional UART RX path, free-running cycle counter and program-stop logic.
- Generates the CPU's ready and io_buffer_full inputs.
- Sits beside the CPU at top level.

---
 rtl/mem_io_responder.sv | 115 +++++++++++
 tb/tb_mem_io_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - byte RAM, UART TX FIFO, cycle counter and stop logic for the CPU memory bus.
// Optional UART RX read path enabled by defining MEM_IO_RX_EN.
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_FIFO_WIDTH  = 3
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        rdy_out,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        halt_out,
  output logic        tx_overflow_out
);

  localparam int DEPTH = 1 << TX_FIFO_WIDTH;
  localparam logic [TX_FIFO_WIDTH:0] FULL_COUNT   = (TX_FIFO_WIDTH+1)'(DEPTH);
  localparam logic [TX_FIFO_WIDTH:0] ALMOST_COUNT = (TX_FIFO_WIDTH+1)'(DEPTH - 1);

  logic [7:0] ram [0:(1<<RAM_ADDR_WIDTH)-1];
  logic [7:0] txFifo [0:DEPTH-1];

  logic [TX_FIFO_WIDTH-1:0] wrPtr, rdPtr;
  logic [TX_FIFO_WIDTH:0]   txCount, txCountNext;
  logic [31:0] cycleCount;
  logic [23:0] snapshot;
  logic isIo, busRd, busWr, txWrSel, stopSel, pushReq, pushOk, popEn, fifoFull;
  logic rxReadHit;
  logic [7:0] ioRdData, rxRdData, pushData;
  logic unusedBits;

  assign isIo    = (mem_a[17:16] == 2'b11);
  assign busWr   = rdy_out & mem_wr;
  assign busRd   = rdy_out & ~mem_wr;
  assign txWrSel = busWr & isIo & (mem_a[15:0] == 16'h0000) & (mem_dout != 8'h00);
  // The stop marker bypasses the zero filter so the UART sees an explicit 0x00.
  assign stopSel = busWr & isIo & (mem_a[15:0] == 16'h0004);
  assign pushReq = txWrSel | stopSel;
  assign pushData = stopSel ? 8'h00 : mem_dout;

  assign tx_valid = (txCount != '0);
  assign tx_data  = txFifo[rdPtr];
  assign popEn    = tx_valid & tx_ready;
  assign fifoFull = (txCount == FULL_COUNT);
  assign pushOk   = pushReq & (~fifoFull | popEn);
  assign txCountNext = txCount + (TX_FIFO_WIDTH+1)'(pushOk) - (TX_FIFO_WIDTH+1)'(popEn);

`ifdef MEM_IO_RX_EN
  assign rxRdData  = rx_valid ? rx_data : 8'h00;
  assign rxReadHit = busRd & isIo & (mem_a[15:0] == 16'h0000) & rx_valid;
  assign unusedBits = ^mem_a[31:18];
`else
  assign rxRdData  = 8'h00;
  assign rxReadHit = 1'b0;
  assign unusedBits = ^{mem_a[31:18], rx_data, rx_valid};
`endif

  always_comb begin
    ioRdData = 8'h00;
    case (mem_a[15:0])
      16'h0000: ioRdData = rxRdData;
      16'h0004: ioRdData = cycleCount[7:0];
      16'h0005: ioRdData = snapshot[7:0];
      16'h0006: ioRdData = snapshot[15:8];
      16'h0007: ioRdData = snapshot[23:16];
      default:  ioRdData = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (busWr & ~isIo) ram[mem_a[RAM_ADDR_WIDTH-1:0]] <= mem_dout;
    if (pushOk) txFifo[wrPtr] <= pushData;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem_din         <= 8'h00;
      rdy_out         <= 1'b0;
      halt_out        <= 1'b0;
      tx_overflow_out <= 1'b0;
      io_buffer_full  <= 1'b0;
      rx_pop          <= 1'b0;
      txCount         <= '0;
      wrPtr           <= '0;
      rdPtr           <= '0;
      cycleCount      <= 32'h0;
      snapshot        <= 24'h0;
    end else begin
      cycleCount      <= cycleCount + 32'h1;
      halt_out        <= halt_out | stopSel;
      rdy_out         <= ~(halt_out | stopSel);
      tx_overflow_out <= tx_overflow_out | (pushReq & ~pushOk);
      txCount         <= txCountNext;
      wrPtr           <= wrPtr + TX_FIFO_WIDTH'(pushOk);
      rdPtr           <= rdPtr + TX_FIFO_WIDTH'(popEn);
      // Almost-full leaves room for the one write already in flight from the CPU.
      io_buffer_full  <= (txCountNext >= ALMOST_COUNT);
      rx_pop          <= rxReadHit;
      if (busRd) begin
        mem_din <= isIo ? ioRdData : ram[mem_a[RAM_ADDR_WIDTH-1:0]];
        if (isIo && mem_a[15:0] == 16'h0004) snapshot <= cycleCount[31:8];
      end
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - self-checking bench for mem_io_responder with a queue-based reference model.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        rdy_out, io_buffer_full, tx_valid, tx_ready, rx_valid, rx_pop;
  logic        halt_out, tx_overflow_out;
  logic [7:0]  tx_data, rx_data;

  int total = 0;
  int bad = 0;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din), .rdy_out(rdy_out),
    .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
    .halt_out(halt_out), .tx_overflow_out(tx_overflow_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model state
  logic [7:0]  mRam [int];
  logic [7:0]  mQ [$];
  logic        mRdy, mHalt, mOvf, mIobf, mRxPop, mDinKnown;
  logic [7:0]  mDin;
  logic [31:0] mCnt;
  logic [23:0] mSnap;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [7:0]  d;
    logic        cd;
    logic [7:0]  ed;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic modelReset();
    mRdy = 0; mHalt = 0; mOvf = 0; mIobf = 0; mRxPop = 0;
    mDin = 8'h00; mDinKnown = 1; mCnt = 0; mSnap = 0;
    mQ.delete();
  endtask

  task automatic modelStep();
    logic [17:0] a;
    bit io, doPush, pop;
    logic [7:0] pd;
    a = mem_a[17:0];
    io = (a[17:16] == 2'b11);
    doPush = 0; pd = 8'h00;
    pop = (mQ.size() > 0) && tx_ready;
    mRxPop = 0;
    if (mRdy) begin
      if (mem_wr) begin
        if (!io) mRam[int'(a[16:0])] = mem_dout;
        else if (a == 18'h30000 && mem_dout != 8'h00) begin doPush = 1; pd = mem_dout; end
        else if (a == 18'h30004) begin doPush = 1; pd = 8'h00; mHalt = 1; end
      end else if (!io) begin
        if (mRam.exists(int'(a[16:0]))) begin mDin = mRam[int'(a[16:0])]; mDinKnown = 1; end
        else mDinKnown = 0;
      end else begin
        mDinKnown = 1;
        case (a)
          18'h30000: begin
`ifdef MEM_IO_RX_EN
            mDin = rx_valid ? rx_data : 8'h00;
            mRxPop = rx_valid;
`else
            mDin = 8'h00;
`endif
          end
          18'h30004: begin mDin = mCnt[7:0]; mSnap = mCnt[31:8]; end
          18'h30005: mDin = mSnap[7:0];
          18'h30006: mDin = mSnap[15:8];
          18'h30007: mDin = mSnap[23:16];
          default:   mDin = 8'h00;
        endcase
      end
    end
    if (pop) void'(mQ.pop_front());
    if (doPush) begin
      if (mQ.size() < 8) mQ.push_back(pd);
      else mOvf = 1;
    end
    mIobf = (mQ.size() >= 7);
    mRdy = !mHalt;
    mCnt = mCnt + 1;
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".rdy"}, rdy_out, mRdy);
    chk({tag, ".halt"}, halt_out, mHalt);
    chk({tag, ".ovf"}, tx_overflow_out, mOvf);
    chk({tag, ".iobf"}, io_buffer_full, mIobf);
    chk({tag, ".txv"}, tx_valid, mQ.size() != 0);
    if (mQ.size() != 0) chk({tag, ".txd"}, tx_data, mQ[0]);
    chk({tag, ".rxpop"}, rx_pop, mRxPop);
    if (mDinKnown) chk({tag, ".din"}, mem_din, mDin);
  endtask

  task automatic setBus(input logic wr, input logic [31:0] a, input logic [7:0] d);
    mem_wr = wr; mem_a = a; mem_dout = d;
  endtask

  task automatic idle();
    setBus(1'b0, 32'h0003_0010, 8'h00);
  endtask

  task automatic tick(input string tag);
    modelStep();
    @(posedge clk_in);
    #1;
    checkAll(tag);
  endtask

  initial begin
    logic [31:0] rnd;
    int r;
    rst_n_in = 0; tx_ready = 0; rx_valid = 0; rx_data = 8'h00;
    idle();
    modelReset();
    repeat (2) @(posedge clk_in);
    #1;
    checkAll("reset");
    rst_n_in = 1;

    tick("rdy_rise");
    chk("rdy_after_release", rdy_out, 1'b1);

    tbl.push_back('{1'b1, 32'h0000_0010, 8'hA5, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 32'h0000_0010, 8'h00, 1'b1, 8'hA5});
    tbl.push_back('{1'b1, 32'h0001_FFFF, 8'h3C, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 32'h0001_FFFF, 8'h00, 1'b1, 8'h3C});
    tbl.push_back('{1'b1, 32'h0000_0020, 8'h11, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 32'hFFFC_0010, 8'h00, 1'b1, 8'hA5});
    tbl.push_back('{1'b0, 32'h0003_0010, 8'h00, 1'b1, 8'h00});
    tbl.push_back('{1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h00});
    tbl.push_back('{1'b1, 32'h0003_0000, 8'h00, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 32'h0003_0008, 8'h77, 1'b0, 8'h00});
    foreach (tbl[i]) begin
      setBus(tbl[i].wr, tbl[i].a, tbl[i].d);
      tick("table");
      if (tbl[i].cd) chk("table_din", mem_din, tbl[i].ed);
    end
    chk("zero_write_no_push", tx_valid, 1'b0);

    // FIFO fill with UART stalled, then overflow, then drain in order
    for (int i = 0; i < 8; i++) begin
      setBus(1'b1, 32'h0003_0000, 8'h41 + 8'(i));
      tick("fill");
      chk("fill_iobf", io_buffer_full, i >= 6);
    end
    chk("ovf_before_9th", tx_overflow_out, 1'b0);
    setBus(1'b1, 32'h0003_0000, 8'h49);
    tick("ovf");
    chk("ovf_after_9th", tx_overflow_out, 1'b1);
    idle();
    tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", tx_valid, 1'b1);
      chk("drain_data", tx_data, 8'h41 + 8'(i));
      tick("drain");
    end
    chk("drain_empty", tx_valid, 1'b0);
    tx_ready = 0;

    // Counter snapshot
    if (mCnt > 32'h1FF) begin
      total++; bad++;
      $display("FAIL cnt_budget: got %0h want <= 1ff", mCnt);
    end else begin
      while (mCnt != 32'h1FF) begin idle(); tick("wait_cnt"); end
      setBus(1'b0, 32'h0003_0004, 8'h00);
      tick("cnt_lo");
      chk("cnt_lo_val", mem_din, 8'hFF);
      setBus(1'b0, 32'h0003_0005, 8'h00);
      tick("snap1");
      chk("snap1_val", mem_din, 8'h01);
      setBus(1'b0, 32'h0003_0006, 8'h00);
      tick("snap2");
      chk("snap2_val", mem_din, 8'h00);
    end

    // Randomized traffic (no stop writes)
    for (int n = 0; n < 400; n++) begin
      rnd = $urandom;
      r = $urandom_range(0, 9);
      tx_ready = ($urandom_range(0, 2) != 0);
      rx_valid = $urandom_range(0, 1);
      rx_data = 8'($urandom);
      case (r)
        0, 1: setBus(1'b1, {rnd[31:18], 2'b00, 12'h010, 4'($urandom_range(0, 15))}, 8'($urandom));
        2, 3: setBus(1'b0, {rnd[31:18], 2'b00, 12'h010, 4'($urandom_range(0, 15))}, 8'h00);
        4, 5: setBus(1'b1, {rnd[31:18], 18'h30000}, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
        6:    setBus(1'b0, {rnd[31:18], 18'h30000}, 8'h00);
        7:    setBus(1'b0, {rnd[31:18], 18'h30004 + 18'($urandom_range(0, 3))}, 8'h00);
        8:    setBus(1'b1, {rnd[31:18], 18'h30010}, 8'($urandom));
        default: setBus(1'b0, {rnd[31:18], 18'h3000C}, 8'h00);
      endcase
      tick("rand");
    end
    rx_valid = 0;

    // Stop: drain, queue two bytes, stop, then reset mid-drain
    idle();
    tx_ready = 1;
    for (int n = 0; n < 10; n++) tick("pre_stop_drain");
    chk("pre_stop_empty", tx_valid, 1'b0);
    tx_ready = 0;
    setBus(1'b1, 32'h0003_0000, 8'h78); tick("stop_x");
    setBus(1'b1, 32'h0003_0000, 8'h79); tick("stop_y");
    setBus(1'b1, 32'h0003_0004, 8'h5A); tick("stop");
    chk("stop_halt", halt_out, 1'b1);
    chk("stop_rdy", rdy_out, 1'b0);
    setBus(1'b1, 32'h0000_0020, 8'h99); tick("ignored_wr");
    tx_ready = 1;
    idle();
    tick("pop_x");
    tick("pop_y");
    chk("stop_marker_valid", tx_valid, 1'b1);
    chk("stop_marker_data", tx_data, 8'h00);
    chk("still_halted", halt_out, 1'b1);
    #3;
    rst_n_in = 0;
    #1;
    chk("async_txv", tx_valid, 1'b0);
    chk("async_halt", halt_out, 1'b0);
    chk("async_rdy", rdy_out, 1'b0);
    chk("async_din", mem_din, 8'h00);
    modelReset();
    @(posedge clk_in);
    #1;
    rst_n_in = 1;
    tick("rdy_rise2");
    setBus(1'b0, 32'h0000_0020, 8'h00);
    tick("ram_kept");
    chk("ram_kept_val", mem_din, 8'h11);

    // RX read
    rx_valid = 1; rx_data = 8'h37;
    setBus(1'b0, 32'h0003_0000, 8'h00);
    tick("rx_read");
`ifdef MEM_IO_RX_EN
    chk("rx_din", mem_din, 8'h37);
    chk("rx_pop_pulse", rx_pop, 1'b1);
`else
    chk("rx_din", mem_din, 8'h00);
    chk("rx_pop_pulse", rx_pop, 1'b0);
`endif
    rx_valid = 0;
    idle();
    tick("rx_after");
    chk("rx_pop_single", rx_pop, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
